// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: write-side front end for the floating-point register file.
// Two FP producers (src0 = add/sub, src1 = mul) each push results into a
// small FIFO. A round-robin arbiter drains the FIFO heads onto the single
// registered write port of the register file, one write per cycle.
//
// Parameters:
//   DEPTH  - entries per source FIFO (power of two, >= 2)
//   DATA_W - result / register-file word width
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   srcN_valid/ready         - producer handshake (ready = FIFO not full)
//   srcN_rd, srcN_data       - destination register and result
//   wr_enable/addr/data      - registered register-file write port
//   idle                     - both FIFOs empty and no write in flight
//
// Optional build macro FP_WB_STATS_EN adds saturating 16-bit counters:
//   wr_cnt0, wr_cnt1         - writes sourced from src0 / src1
//   stall_cnt                - cycles where any source is valid but not ready
module fp_wb_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src0_valid,
   output logic              src0_ready,
   input  logic [4:0]        src0_rd,
   input  logic [DATA_W-1:0] src0_data,
   input  logic              src1_valid,
   output logic              src1_ready,
   input  logic [4:0]        src1_rd,
   input  logic [DATA_W-1:0] src1_data,
   output logic              wr_enable,
   output logic [4:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              idle
`ifdef FP_WB_STATS_EN
   ,
   output logic [15:0]       wr_cnt0,
   output logic [15:0]       wr_cnt1,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

   logic [1:0]        in_valid;
   logic [1:0]        in_ready;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        not_empty;
   logic [4:0]        in_rd     [2];
   logic [DATA_W-1:0] in_data   [2];
   logic [4:0]        head_rd   [2];
   logic [DATA_W-1:0] head_data [2];
   src_t              last_grant;
   src_t              last_grant_next;

   assign in_valid   = {src1_valid, src0_valid};
   assign in_rd[0]   = src0_rd;
   assign in_rd[1]   = src1_rd;
   assign in_data[0] = src0_data;
   assign in_data[1] = src1_data;
   assign src0_ready = in_ready[0];
   assign src1_ready = in_ready[1];

   for (genvar s = 0; s < 2; s++) begin : g_fifo
      logic [4:0]        mem_rd   [DEPTH];
      logic [DATA_W-1:0] mem_data [DEPTH];
      logic [PTR_W-1:0]  wptr;
      logic [PTR_W-1:0]  rptr;
      logic [CNT_W-1:0]  count;

      // Ready depends on occupancy only: a full FIFO refuses even while popping.
      assign in_ready[s]  = (count < CNT_W'(DEPTH));
      // Writes to x0 complete the handshake but are never queued.
      assign push[s]      = in_valid[s] && in_ready[s] && (in_rd[s] != 5'd0);
      assign not_empty[s] = (count != '0);
      assign head_rd[s]   = mem_rd[rptr];
      assign head_data[s] = mem_data[rptr];

      always_ff @(posedge clk) begin
         if (push[s]) begin
            mem_rd[wptr]   <= in_rd[s];
            mem_data[wptr] <= in_data[s];
         end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk) begin
         if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push[s]) wptr <= wptr + PTR_W'(1);
            if (pop[s])  rptr <= rptr + PTR_W'(1);
            case ({push[s], pop[s]})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) last_grant <= SRC1;
      else     last_grant <= last_grant_next;
   end

   // Round robin: on contention the source that did not win last time goes.
   always_comb begin
      pop             = '0;
      last_grant_next = last_grant;
      if (not_empty[0] && (!not_empty[1] || last_grant == SRC1)) begin
         pop[0]          = 1'b1;
         last_grant_next = SRC0;
      end else if (not_empty[1]) begin
         pop[1]          = 1'b1;
         last_grant_next = SRC1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_enable <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         wr_enable <= |pop;
         if (pop[0]) begin
            wr_addr <= head_rd[0];
            wr_data <= head_data[0];
         end else if (pop[1]) begin
            wr_addr <= head_rd[1];
            wr_data <= head_data[1];
         end
      end
   end

   assign idle = !not_empty[0] && !not_empty[1] && !wr_enable;

`ifdef FP_WB_STATS_EN
   logic stall;

   assign stall = |(in_valid & ~in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt0   <= '0;
         wr_cnt1   <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop[0] && wr_cnt0 != '1)   wr_cnt0   <= wr_cnt0 + 16'd1;
         if (pop[1] && wr_cnt1 != '1)   wr_cnt1   <= wr_cnt1 + 16'd1;
         if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
